// File: rtl/sprite_pkg.sv
`default_nettype none
//============================================================================
// Package  : sprite_pkg
// Purpose  : Shared types and constants for the multi-sprite compositor:
//            config field encoding, 6-bit rrggbb colour type and default
//            colours.
// Revision : 1.0 - initial release
//============================================================================
package sprite_pkg;

   // Config field selector carried on the write bus
   typedef enum logic [1:0] {
      FIELD_X    = 2'd0,
      FIELD_Y    = 2'd1,
      FIELD_ATTR = 2'd2,
      FIELD_ROW  = 2'd3
   } wr_field_e;

   typedef logic [5:0] rgb_t;

   localparam rgb_t c_RGB_BLACK = 6'b000000;
   localparam rgb_t c_RGB_WHITE = 6'b111111;

   // Sprite positions live in an 8-bit big-pixel coordinate space
   localparam int c_COORD_W = 8;

endpackage : sprite_pkg
`default_nettype wire

// File: rtl/multi_sprite_compositor_if.sv
`default_nettype none
//============================================================================
// Interface: multi_sprite_compositor_if
// Purpose  : Single-cycle sprite configuration write bus.
// Signals  : wr_en     - write strobe, one cycle per write
//            wr_sprite - target sprite index
//            wr_field  - X / Y / {enable,colour} / bitmap row
//            wr_row    - bitmap row index (FIELD_ROW only)
//            wr_data   - write data, LSB-aligned
// Modports : master (configuration source), slave (compositor)
// Revision : 1.0 - initial release
//============================================================================
interface multi_sprite_compositor_if;
   import sprite_pkg::*;

   logic        wr_en;
   logic [2:0]  wr_sprite;
   wr_field_e   wr_field;
   logic [3:0]  wr_row;
   logic [15:0] wr_data;

   modport master (output wr_en, wr_sprite, wr_field, wr_row, wr_data);
   modport slave  (input  wr_en, wr_sprite, wr_field, wr_row, wr_data);

endinterface : multi_sprite_compositor_if
`default_nettype wire

// File: rtl/sprite_unit.sv
`default_nettype none
//============================================================================
// Module   : sprite_unit
// Purpose  : One 1-bit sprite. Holds staging and active position/attribute
//            registers plus the bitmap, and produces a combinational hit for
//            the current downscaled coordinate.
// Ports    : clk_i, rst_ni     - clock, async active-low reset
//            next_frame_i      - frame-start pulse, staging -> active
//            wr_en_i           - write strobe already qualified for this unit
//            wr_field_i        - field selector
//            wr_row_i          - bitmap row index
//            wr_data_i         - write data
//            cs_h_i, cs_v_i    - signed downscaled coordinates
//            hit_o             - opaque sprite pixel at (cs_h_i, cs_v_i)
//            color_o           - active sprite colour
// Revision : 1.0 - initial release
//============================================================================
module sprite_unit
   import sprite_pkg::*;
#(
   parameter int SPRITE_WIDTH  = 12,
   parameter int SPRITE_HEIGHT = 12,
   parameter int CNT_W         = 11
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             next_frame_i,
   input  logic             wr_en_i,
   input  wr_field_e        wr_field_i,
   input  logic [3:0]       wr_row_i,
   input  logic [15:0]      wr_data_i,
   input  logic [CNT_W-1:0] cs_h_i,
   input  logic [CNT_W-1:0] cs_v_i,
   output logic             hit_o,
   output rgb_t             color_o
);

   localparam int c_COL_W = (SPRITE_WIDTH  > 1) ? $clog2(SPRITE_WIDTH)  : 1;
   localparam int c_ROW_W = (SPRITE_HEIGHT > 1) ? $clog2(SPRITE_HEIGHT) : 1;

   localparam logic [CNT_W:0] c_WIDTH  = (CNT_W+1)'(SPRITE_WIDTH);
   localparam logic [CNT_W:0] c_HEIGHT = (CNT_W+1)'(SPRITE_HEIGHT);
   localparam logic [4:0]     c_ROWS   = 5'(SPRITE_HEIGHT);

   logic [c_COORD_W-1:0]    r_stg_x, r_stg_y, r_act_x, r_act_y;
   logic                    r_stg_en, r_act_en;
   rgb_t                    r_stg_col, r_act_col;
   logic [SPRITE_WIDTH-1:0] r_bitmap [SPRITE_HEIGHT];

   logic [CNT_W:0]          w_dx, w_dy;
   logic [SPRITE_WIDTH-1:0] w_row;
   logic                    w_in_box;
   logic                    w_row_ok;
   logic                    w_unused_data;

   assign w_row_ok      = ({1'b0, wr_row_i} < c_ROWS);
   assign w_unused_data = ^wr_data_i;

   // Staging takes writes; active copies staging at frame start. A write in
   // the frame-start cycle updates staging only, so active sees it one frame
   // later.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_stg_x   <= '0;
         r_stg_y   <= '0;
         r_stg_en  <= 1'b0;
         r_stg_col <= c_RGB_BLACK;
         r_act_x   <= '0;
         r_act_y   <= '0;
         r_act_en  <= 1'b0;
         r_act_col <= c_RGB_BLACK;
      end else begin
         if (wr_en_i) begin
            case (wr_field_i)
               FIELD_X:    r_stg_x <= wr_data_i[c_COORD_W-1:0];
               FIELD_Y:    r_stg_y <= wr_data_i[c_COORD_W-1:0];
               FIELD_ATTR: begin
                  r_stg_en  <= wr_data_i[6];
                  r_stg_col <= wr_data_i[5:0];
               end
               default: ;
            endcase
         end
         if (next_frame_i) begin
            r_act_x   <= r_stg_x;
            r_act_y   <= r_stg_y;
            r_act_en  <= r_stg_en;
            r_act_col <= r_stg_col;
         end
      end
   end

   // Bitmap rows are written straight into the live bitmap
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int r = 0; r < SPRITE_HEIGHT; r++) begin
            r_bitmap[r] <= '0;
         end
      end else if (wr_en_i && (wr_field_i == FIELD_ROW) && w_row_ok) begin
         r_bitmap[wr_row_i[c_ROW_W-1:0]] <= wr_data_i[SPRITE_WIDTH-1:0];
      end
   end

   // Offsets at CNT_W+1 bits: a negative offset becomes a large unsigned
   // value and fails the range check, so sprites clip instead of wrapping.
   assign w_dx = {cs_h_i[CNT_W-1], cs_h_i} - {{(CNT_W+1-c_COORD_W){1'b0}}, r_act_x};
   assign w_dy = {cs_v_i[CNT_W-1], cs_v_i} - {{(CNT_W+1-c_COORD_W){1'b0}}, r_act_y};

   assign w_in_box = r_act_en && !cs_h_i[CNT_W-1] && !cs_v_i[CNT_W-1] &&
                     (w_dx < c_WIDTH) && (w_dy < c_HEIGHT);

   assign w_row   = r_bitmap[w_dy[c_ROW_W-1:0]];
   assign hit_o   = w_in_box && w_row[w_dx[c_COL_W-1:0]];
   assign color_o = r_act_col;

endmodule : sprite_unit
`default_nettype wire

// File: rtl/multi_sprite_compositor.sv
`default_nettype none
//============================================================================
// Module   : multi_sprite_compositor
// Purpose  : Composites NUM_SPRITES 1-bit sprites over the background in a
//            downscaled coordinate space, with fixed priority (index 0
//            highest), frame-synchronous position update and per-frame
//            sprite-sprite collision reporting.
// Ports    : clk_i, rst_ni   - pixel clock, async active-low reset
//            counter_h_i/v_i - signed timing counters
//            blank_i         - hblank | vblank
//            next_frame_i    - frame-start pulse
//            bg_color_i      - background rrggbb
//            cfg             - configuration write bus (slave)
//            rrggbb_o        - registered composited colour (1 cycle)
//            collision_o     - sprites that collided in the previous frame
// Revision : 1.0 - initial release
//============================================================================
module multi_sprite_compositor
   import sprite_pkg::*;
#(
   parameter int NUM_SPRITES   = 4,
   parameter int SPRITE_WIDTH  = 12,
   parameter int SPRITE_HEIGHT = 12,
   parameter int SCALE_LOG2    = 3,
   parameter int CNT_W         = 11
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic signed [CNT_W-1:0] counter_h_i,
   input  logic signed [CNT_W-1:0] counter_v_i,
   input  logic                    blank_i,
   input  logic                    next_frame_i,
   input  rgb_t                    bg_color_i,
   multi_sprite_compositor_if.slave cfg,
   output rgb_t                    rrggbb_o,
   output logic [NUM_SPRITES-1:0]  collision_o
);

   logic signed [CNT_W-1:0] w_cs_h, w_cs_v;
   logic [NUM_SPRITES-1:0]  w_hit;
   rgb_t                    w_color [NUM_SPRITES];
   rgb_t                    w_pix;
   logic                    w_multi;
   logic [NUM_SPRITES-1:0]  w_coll_in;

   rgb_t                    r_rrggbb;
   logic [NUM_SPRITES-1:0]  r_coll_acc;
   logic [NUM_SPRITES-1:0]  r_collision;

   // Arithmetic shift keeps porch/sync regions negative
   assign w_cs_h = counter_h_i >>> SCALE_LOG2;
   assign w_cs_v = counter_v_i >>> SCALE_LOG2;

   for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_sprite
      logic w_sel;
      // Indices with no matching unit simply select nothing
      assign w_sel = cfg.wr_en && (cfg.wr_sprite == 3'(gi));

      sprite_unit #(
         .SPRITE_WIDTH  (SPRITE_WIDTH),
         .SPRITE_HEIGHT (SPRITE_HEIGHT),
         .CNT_W         (CNT_W)
      ) u_sprite (
         .clk_i        (clk_i),
         .rst_ni       (rst_ni),
         .next_frame_i (next_frame_i),
         .wr_en_i      (w_sel),
         .wr_field_i   (cfg.wr_field),
         .wr_row_i     (cfg.wr_row),
         .wr_data_i    (cfg.wr_data),
         .cs_h_i       (w_cs_h),
         .cs_v_i       (w_cs_v),
         .hit_o        (w_hit[gi]),
         .color_o      (w_color[gi])
      );
   end

   // Scan from lowest priority upward so the lowest hitting index wins
   always_comb begin
      w_pix = bg_color_i;
      for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
         if (w_hit[i]) begin
            w_pix = w_color[i];
         end
      end
      if (blank_i) begin
         w_pix = c_RGB_BLACK;
      end
   end

   // Clearing the lowest set bit leaves something only if two or more hit
   assign w_multi   = |(w_hit & (w_hit - NUM_SPRITES'(1)));
   assign w_coll_in = (!blank_i && w_multi) ? w_hit : '0;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_rrggbb    <= c_RGB_BLACK;
         r_coll_acc  <= '0;
         r_collision <= '0;
      end else begin
         r_rrggbb <= w_pix;
         if (next_frame_i) begin
            r_collision <= r_coll_acc;
            // A collision in the frame-start cycle belongs to the new frame
            r_coll_acc  <= w_coll_in;
         end else begin
            r_coll_acc  <= r_coll_acc | w_coll_in;
         end
      end
   end

   assign rrggbb_o    = r_rrggbb;
   assign collision_o = r_collision;

endmodule : multi_sprite_compositor
`default_nettype wire
